// File: rtl/minitb_ahb_pkg.sv
// Shared AHB arbiter types: htrans encodings and the arbiter state enum.
package minitb_ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    StPark,
    StOwned,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/minitb_ahb_arbiter_if.sv
// Arbiter bus bundle: master requests in, one-hot grant and address-phase owner out.
interface minitb_ahb_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [IdxW-1:0]        hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/minitb_rr_picker.sv
// Combinational round-robin search: first set request bit at or after start_i, wrapping.
module minitb_rr_picker #(
  parameter int unsigned NUM_MASTERS = 4,
  localparam int unsigned IdxW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IdxW-1:0]        start_i,
  output logic [NUM_MASTERS-1:0] grant_oh_o,
  output logic [IdxW-1:0]        grant_idx_o
);

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand     = (32'(start_i) + i) % NUM_MASTERS;
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found                 = 1'b1;
        grant_oh_o[cand_idx]  = 1'b1;
        grant_idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/minitb_ahb_arbiter.sv
// AHB bus arbiter: round-robin with burst hold limit and parking on DEFAULT_MASTER.
// Locked transfers are supported only when MINITB_AHB_ARB_LOCK_EN is defined.
module minitb_ahb_arbiter
  import minitb_ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input logic                 hclk,
  input logic                 hresetn,
  minitb_ahb_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [IdxW-1:0]        DefaultIdx = IdxW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DefaultOh  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [CntW-1:0]        hold_cnt_q, hold_cnt_d;

  logic [IdxW-1:0]        start_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IdxW-1:0]        pick_idx;
  logic                   any_req, owner_req, others_req, burst, cap_hit, owner_lock;

  // Search starts just past the owner so the owner is considered last.
  assign start_idx = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

  minitb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req_i       (bus.hbusreq),
    .start_i     (start_idx),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

  assign any_req    = |bus.hbusreq;
  assign owner_req  = bus.hbusreq[owner_q];
  assign others_req = |(bus.hbusreq & ~grant_q);
  assign burst      = (bus.htrans == TransSeq) || (bus.htrans == TransBusy);
  // This edge would complete MAX_HOLD cycles of tenure.
  assign cap_hit    = (hold_cnt_q >= CntW'(MAX_HOLD - 1)) && others_req;

`ifdef MINITB_AHB_ARB_LOCK_EN
  assign owner_lock = bus.hlock[owner_q];
`else
  logic unused_hlock;
  assign unused_hlock = ^bus.hlock;
  assign owner_lock   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    hold_cnt_d  = hold_cnt_q;
    if (bus.hready) begin
      hmaster_d   = owner_q;
      hmastlock_d = owner_lock;
      if (state_q == StLocked && owner_lock) begin
        state_d = StLocked;
      end else if (!any_req) begin
        state_d = StPark;
        grant_d = DefaultOh;
        owner_d = DefaultIdx;
      end else if (state_q != StPark && owner_req && owner_lock) begin
        state_d = StLocked;
      end else if (state_q != StPark && owner_req && burst && !cap_hit) begin
        state_d = StOwned;
      end else begin
        state_d = StOwned;
        grant_d = pick_oh;
        owner_d = pick_idx;
      end
      if (grant_d != grant_q) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q < CntW'(MAX_HOLD)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StPark;
      grant_q     <= DefaultOh;
      owner_q     <= DefaultIdx;
      hmaster_q   <= DefaultIdx;
      hmastlock_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: doc/minitb_ahb_arbiter.md
MINITB_AHB_ARBITER -- requirements
Module: minitb_ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, meaning number of requesting masters; SHALL be legal from 2 to 16.
REQ-002 Parameter DEFAULT_MASTER, default 0, meaning parked master index when no request is pending.
REQ-003 Parameter MAX_HOLD, default 16, meaning maximum consecutive hready-qualified cycles one master may keep the bus while others request.
REQ-004 Port hclk, input, 1, meaning bus clock; the block SHALL have one clock, and all state SHALL update on its rising edge.
REQ-005 Port hresetn, input, 1, meaning reset; it SHALL be asynchronous and active-low.
REQ-006 Port hbusreq, input, NUM_MASTERS, meaning per-master bus request.
REQ-007 Port hlock, input, NUM_MASTERS, meaning per-master locked-transfer request.
REQ-008 Port htrans, input, 2, meaning transfer type driven by the current address-phase owner.
REQ-009 Port hready, input, 1, meaning transfer complete / bus advance.
REQ-010 Port hgrant, output, NUM_MASTERS, meaning one-hot grant.
REQ-011 Port hmaster, output, $clog2(NUM_MASTERS), meaning index of the address-phase owner.
REQ-012 Port hmastlock, output, 1, meaning the current address-phase transfer is locked.

Function
REQ-013 hgrant SHALL be registered, SHALL be exactly one-hot at all times, and SHALL change only on edges where hready=1.
REQ-014 hmaster SHALL load the index of the granted master on each edge where hready=1, one hready cycle after the grant, and SHALL hold otherwise.
REQ-015 State machine states SHALL be PARK, OWNED and LOCKED.
- PARK: no request pending; DEFAULT_MASTER is granted.
- OWNED: a requester holds the grant.
- LOCKED: the owner asserted hlock.
REQ-016 When hready=1 in OWNED, the grant SHALL be held if both hold: the owner's hbusreq=1, and htrans is SEQ or BUSY.
REQ-017 A grant held under REQ-016 SHALL stop being held once the hold counter reaches MAX_HOLD while another master requests.
REQ-018 Otherwise, when hready=1, the next grant SHALL be the first requester found searching round-robin from (owner+1) mod NUM_MASTERS; the owner SHALL be included last.
REQ-019 If no hbusreq bit is set when hready=1, the block SHALL grant DEFAULT_MASTER and enter PARK.
REQ-020 From PARK, any request seen with hready=1 SHALL produce a grant at the next edge, which is one-cycle arbitration latency.
REQ-021 The hold counter SHALL increment on each hready=1 edge while the grant is unchanged, SHALL saturate at MAX_HOLD, and SHALL clear to 0 on any grant change.
REQ-022 If the owner drops hbusreq while hready=0, the grant SHALL remain unchanged until the next hready=1 edge.
REQ-023 Simultaneous requests from all masters SHALL be served in strict rotation, one tenure each.
REQ-024 Inputs from a granted master with an index outside 0..NUM_MASTERS-1 cannot occur; unused encodings of hmaster SHALL never be driven.

Reset
REQ-025 Asserting hresetn low SHALL immediately, without waiting for hclk, drive all of the following:
- hgrant to one-hot DEFAULT_MASTER;
- hmaster to DEFAULT_MASTER;
- hmastlock to 0;
- state to PARK;
- round-robin pointer to DEFAULT_MASTER;
- hold counter to 0.
REQ-026 Reset asserted mid-tenure, including in LOCKED, SHALL discard ownership; arbitration SHALL restart from PARK on the first hclk edge after deassertion.

Configuration
REQ-027 Macro MINITB_AHB_ARB_LOCK_EN defined: LOCKED SHALL be entered when hready=1 and the owner's hbusreq and hlock are both 1.
- While LOCKED, the grant SHALL be held regardless of other requests and MAX_HOLD.
- LOCKED SHALL be left at the first hready=1 edge with the owner's hlock=0, followed by normal arbitration.
- hmastlock SHALL follow the owner's hlock with the same one-hready-cycle timing as hmaster.
REQ-028 Macro MINITB_AHB_ARB_LOCK_EN undefined: hlock SHALL be ignored, LOCKED SHALL be unreachable, and hmastlock SHALL be tied to 0.

Structure
REQ-029 Shared package minitb_ahb_pkg SHALL hold:
- htrans encodings IDLE=00, BUSY=01, NONSEQ=10, SEQ=11;
- the arbiter state enum.
REQ-030 Round-robin search SHALL be a combinational sub-module minitb_rr_picker, with inputs request vector and start index, and outputs one-hot and index.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Reset, then no requests: hgrant=0001, hmaster=0, hmastlock=0.
- hbusreq=0110 with hready=1: hgrant=0010 at the first edge, hmaster=1 at the second; owner drops hbusreq with htrans=IDLE, then hgrant=0100.
- hbusreq=1111, htrans=NONSEQ every cycle: grant order 0,1,2,3,0; each grant lasts 1 cycle.
- Master 1 holds htrans=SEQ with master 2 requesting, MAX_HOLD=16: hgrant switches to 0100 exactly 16 hready cycles after master 1's grant.
- hready=0 for 5 cycles while master 0 drops hbusreq: hgrant and hmaster remain stable until hready=1.
- With MINITB_AHB_ARB_LOCK_EN, master 3 sets hlock and SEQ for 40 cycles with others requesting: no grant change, hmastlock=1, grant moves to master 0 after hlock drops; hresetn pulsed mid-lock returns to PARK immediately.
